// File: rtl/mux8_sel_arbiter_if.sv
// Request/grant bundle between eight requesters and the shared-mux arbiter.
// The master side drives requests and done; the slave (arbiter) returns the grant.
interface mux8_sel_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] selection;
    logic       valid;

    modport master (
        output req,
        output done,
        input  grant,
        input  selection,
        input  valid
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output selection,
        output valid
    );
endinterface

// File: rtl/mux8_sel_arbiter.sv
// Round-robin arbiter steering a shared 8:1 mux; bounds how long one owner
// may keep the mux while others wait.
module mux8_sel_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               reset,
    mux8_sel_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [7:0]       grant_q;
    logic [2:0]       sel_q;
    logic             valid_q;

    logic [7:0]       others;
    logic [7:0]       eligible;
    logic             release_now;
    logic [2:0]       next_ptr;
    logic [3:0]       idle_pick;
    logic [3:0]       rel_pick;

    // Returns {found, index} of the first set bit scanning p, p+1, ... mod 8.
    // Scanning from the far end keeps the lowest offset as the final winner.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // While granted, sel_q names the owner; a done release re-offers the owner
    // itself, but pick from owner+1 makes it the last choice.
    always_comb begin
        others      = bus.req & ~grant_q;
        release_now = bus.done | ~bus.req[sel_q] |
                      ((hold_cnt == HOLD_LAST) && (|others));
        eligible    = bus.done ? bus.req : others;
        next_ptr    = sel_q + 3'd1;
        idle_pick   = pick(bus.req, ptr);
        rel_pick    = pick(eligible, next_ptr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= '0;
            grant_q  <= 8'h00;
            sel_q    <= 3'd0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[3]) begin
                        grant_q  <= 8'd1 << idle_pick[2:0];
                        sel_q    <= idle_pick[2:0];
                        valid_q  <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (release_now) begin
                        ptr      <= next_ptr;
                        hold_cnt <= '0;
                        if (rel_pick[3]) begin
                            grant_q <= 8'd1 << rel_pick[2:0];
                            sel_q   <= rel_pick[2:0];
                        end else begin
                            // selection stays put so the mux output is stable
                            grant_q <= 8'h00;
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.selection = sel_q;
    assign bus.valid     = valid_q;
endmodule

// File: doc/mux8_sel_arbiter.md
Name: mux8_sel_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux between 8 requesters.
- Accepts 8 request lines and issues a one-hot grant to exactly one requester.
- Drives the registered 3-bit `selection` into the shared mux so the winner's signal reaches the consumer.
- Bounds how long any requester may hold the mux while others are waiting.

Parameters:
- HOLD_MAX, 16: maximum consecutive cycles one owner may keep a grant while any other request is pending. Legal values are 2 to 256.
- CNT_W, $clog2(HOLD_MAX): width of the hold counter. Derived; never overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous reset, active-high.
- req  input  8  request vector; req[i] means requester i wants the mux.
- done  input  1  current owner signals it has finished. Sampled only while valid=1.
- grant  output  8  one-hot registered grant; all zeros when no owner.
- selection  output  3  registered mux select, equal to the index of the set grant bit.
- valid  output  1  high whenever grant is non-zero.

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high, and clears all state immediately, independent of clk.
- Reset values: grant=8'h00, selection=3'd0, valid=0, state=IDLE, ptr=3'd0, hold_cnt=0.
- Internal state:
  - ptr: highest-priority index.
  - hold_cnt: cycles the current owner has held the grant.
  - 2-state FSM: IDLE and GRANTED.
- Arbitration function pick(req, ptr): the first set bit scanning ptr, ptr+1, ... ,7, 0, ... ,ptr-1, with indices taken mod 8.
- IDLE:
  - If req==0: stay in IDLE; outputs unchanged.
  - Otherwise, at the next edge:
    - grant = onehot(pick(req, ptr));
    - selection = pick(req, ptr);
    - valid=1, hold_cnt=0, go to GRANTED.
  - Latency from req asserted to grant visible is 1 cycle.
- GRANTED, owner o. Release occurs when any of the following is true:
  - (a) done=1;
  - (b) req[o]=0;
  - (c) hold_cnt==HOLD_MAX-1 and (req & ~onehot(o))!=0 (preemption).
- On release:
  - ptr <= o+1 mod 8.
  - Arbitration in the same cycle uses the new priority order, which makes o the lowest-priority requester.
  - With E = req & ~onehot(o) for cases (b) and (c), and E = req for case (a): if E!=0, grant transfers directly to pick(E, o+1) at the next edge with no bubble, and hold_cnt=0.
  - If E==0, go to IDLE with grant=0 and valid=0.
- No release: grant is held, and hold_cnt increments, saturating at HOLD_MAX-1.
- If the owner is alone, it holds indefinitely. Preemption never fires without a competing requester.
- selection is not cleared on release to IDLE. It keeps the last owner's index so the mux output stays stable.
- done while valid=0 is ignored.
- Invariants, checked every cycle:
  - grant is zero or one-hot.
  - valid == |grant.
  - When valid=1, grant[selection]=1.
- Ownership does not change except on a release condition.
- Reset mid-grant: outputs clear asynchronously. After reset deasserts, arbitration restarts from ptr=0.
- Starvation bound: a continuously asserted request is granted within 7*HOLD_MAX + 1 cycles.

Test Plan:
- Reset then idle: reset pulse with req=0 → grant=0, selection=0, valid=0, held for 10 cycles.
- Basic grant and rotation:
  - req=8'b0000_0101 from reset → grant=8'h01, selection=0 after 1 cycle.
  - done pulse → next cycle grant=8'h04, selection=2 (no bubble).
  - done again → grant=8'h01.
- Wrap-around: set ptr to 6 by granting requester 5 and releasing; req=8'b1000_0010 → grant=8'h80, selection=7; then done → grant=8'h02, selection=1.
- Preemption with HOLD_MAX=4:
  - req=8'h03, done=0 → requester 0 holds grant=8'h01 for exactly 4 cycles, then grant=8'h02.
  - With req=8'h01 alone, requester 0 holds for 50 cycles with no change.
- Drop request: owner 3 deasserts req[3] with req=8'h08→8'h00 → next cycle grant=0, valid=0, selection stays 3.
- Asynchronous reset mid-grant: while grant=8'h10, assert reset between clock edges → grant=0, valid=0, selection=0 immediately. After release with req=8'hFF → grant=8'h01.
